cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory line port between the I-cache (read-only misses) and the D-cache (read misses and write-backs).
- Sits between the two L1 caches and pmem, below the IF and MEM pipeline stages.
- D-cache has fixed priority because MEM-stage misses are older than IF-stage misses; a streak counter bounds I-cache starvation.
- One transaction is outstanding at a time; there is no pipelining of pmem requests.

Parameters:
- LINE_W, 256, cache line width in bits.
- ADDR_W, 32, byte address width.
- MAX_D_STREAK, 4, number of consecutive D grants allowed while an I request waits; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_read  in  1  I-cache line-read request; held until i_resp.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line returned to the I-cache.
- i_resp  out  1  one-cycle completion pulse to the I-cache.
- d_read  in  1  D-cache line-read request.
- d_write  in  1  D-cache line write-back request.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  write-back line.
- d_rdata  out  LINE_W  line returned to the D-cache.
- d_resp  out  1  one-cycle completion pulse to the D-cache.
- pmem_read  out  1  read strobe to memory.
- pmem_write  out  1  write strobe to memory.
- pmem_addr  out  ADDR_W  memory address.
- pmem_wdata  out  LINE_W  memory write data.
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory completion pulse.

Behaviour:
- States:
  - IDLE: no grant.
  - SERVE_I: granted to I.
  - SERVE_D_RD: granted to D read.
  - SERVE_D_WR: granted to D write-back.
- Reset (rst_n low at a clk edge):
  - state goes to IDLE; streak counter cleared to 0.
  - All outputs 0 in the following cycle: pmem_read, pmem_write, pmem_addr, pmem_wdata, i_resp, d_resp, i_rdata, d_rdata.
- IDLE arbitration (one arbitration per cycle, registered into state):
  - D pending (d_read or d_write) and not (i_read and streak == MAX_D_STREAK): go to SERVE_D_WR if d_write, else SERVE_D_RD.
  - Otherwise, if i_read: go to SERVE_I.
  - Otherwise: stay in IDLE.
- Illegal stimulus: d_read and d_write both high is illegal. The bench flags it; the RTL gives d_write precedence.
- SERVE_* outputs (combinational from state):
  - pmem_read = 1 in SERVE_I and SERVE_D_RD.
  - pmem_write = 1 in SERVE_D_WR.
  - pmem_addr = granted requester's address.
  - pmem_wdata = d_wdata, otherwise 0.
  - Strobes stay asserted until pmem_resp.
- Completion:
  - When pmem_resp is high in SERVE_X, the matching x_resp is driven high in that same cycle (combinational pass-through).
  - x_rdata = pmem_rdata in that cycle; x_rdata is 0 in all other cycles.
  - The non-granted requester's resp stays 0.
  - Next state is IDLE, so every transaction has at least one IDLE cycle after completion. This lets the requester drop its request before re-arbitration.
- Latency:
  - Request seen in IDLE at cycle t: pmem strobe is high in cycle t+1.
  - Best-case x_resp is at t+1 if memory responds in the same cycle.
- Streak counter (4-bit), updated on each grant decision in IDLE:
  - D granted while i_read is high: increment, saturating at MAX_D_STREAK.
  - I granted: clear to 0.
  - No I request pending (i_read low): clear to 0.
  - Consequence: I waits at most MAX_D_STREAK D transactions.
- Request changes mid-transaction:
  - Requests dropping during SERVE_* are ignored; the transaction completes when pmem_resp arrives.
  - pmem_resp arriving in IDLE is ignored; no resp is generated.
- Reset mid-transaction: the transaction is abandoned and strobes drop the next cycle. Memory tolerates a withdrawn strobe.
- No combinational path from pmem_resp to pmem_read or pmem_write.

Decomposition:
- Shared package rv32i_types gets:
  - enum arb_state_t: IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR.
  - typedef rv32i_line = logic [255:0].
- No sub-module is natural. The FSM, streak counter and output mux fit in one module of roughly 150 lines.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with i_read=1 and d_write=1 → all outputs 0; state IDLE on release; first grant is D write at the next cycle.
- Single I read: i_read=1, i_addr=0x0000_0100; pmem_resp after 3 cycles with pmem_rdata=256'hA5… → pmem_read high for 3 cycles with pmem_addr=0x100; i_resp pulses 1 cycle with i_rdata=A5…; d_resp stays 0.
- Collision: i_read and d_read raised in the same cycle → D served first; after D's resp plus one IDLE cycle, I is served.
- Starvation guard: MAX_D_STREAK=4; i_read held while D issues 6 back-to-back reads → grant order D,D,D,D,I,D,D.
- Write-back: d_write=1, d_addr=0x8000_0040, d_wdata=256'h1234… → pmem_write=1, pmem_wdata=1234…, pmem_read=0; d_resp on pmem_resp; d_rdata=0 except during the resp cycle.
- Mid-transaction reset: assert rst_n=0 two cycles into SERVE_I → pmem_read=0 the next cycle; a later stray pmem_resp produces no i_resp.

Source files
------------

// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types
// Description : Shared types for the L1-to-pmem path (line type and the
//               memory-arbiter grant state).
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

   typedef logic [255:0] rv32i_line;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SERVE_I    = 2'd1,
      SERVE_D_RD = 2'd2,
      SERVE_D_WR = 2'd3
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares the single pmem line port between the I-cache and the
//               D-cache. D has fixed priority; a saturating streak counter
//               bounds how many D grants may pass a waiting I request.
//               One transaction outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
   parameter int LINE_W       = 256,
   parameter int ADDR_W       = 32,
   parameter int MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);
   import rv32i_types::*;

   localparam logic [3:0] c_max_streak = 4'(MAX_D_STREAK);

   arb_state_t state_q, state_d;
   logic [3:0] streak_q, streak_d;

   logic w_d_pend;
   logic w_i_block;

   assign w_d_pend  = d_read | d_write;
   assign w_i_block = i_read && (streak_q == c_max_streak);

   // State and streak registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         streak_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
      end
   end

   // Next-state: arbitrate in IDLE, hold a grant until pmem_resp.
   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      unique case (state_q)
         IDLE: begin
            if (w_d_pend && !w_i_block) begin
               // d_write wins if both D strobes are (illegally) high.
               state_d = d_write ? SERVE_D_WR : SERVE_D_RD;
               if (!i_read) begin
                  streak_d = 4'd0;
               end else if (streak_q != c_max_streak) begin
                  streak_d = streak_q + 4'd1;
               end
            end else if (i_read) begin
               state_d  = SERVE_I;
               streak_d = 4'd0;
            end else begin
               streak_d = 4'd0;
            end
         end
         SERVE_I, SERVE_D_RD, SERVE_D_WR: begin
            // Always return through IDLE so the requester can drop its request.
            if (pmem_resp) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output mux: strobes depend only on state; responses pass pmem_resp through.
   always_comb begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      pmem_addr  = '0;
      pmem_wdata = '0;
      i_resp     = 1'b0;
      d_resp     = 1'b0;
      i_rdata    = '0;
      d_rdata    = '0;
      unique case (state_q)
         SERVE_I: begin
            pmem_read = 1'b1;
            pmem_addr = i_addr;
            i_resp    = pmem_resp;
            i_rdata   = pmem_resp ? pmem_rdata : '0;
         end
         SERVE_D_RD: begin
            pmem_read = 1'b1;
            pmem_addr = d_addr;
            d_resp    = pmem_resp;
            d_rdata   = pmem_resp ? pmem_rdata : '0;
         end
         SERVE_D_WR: begin
            pmem_write = 1'b1;
            pmem_addr  = d_addr;
            pmem_wdata = d_wdata;
            d_resp     = pmem_resp;
            d_rdata    = pmem_resp ? pmem_rdata : '0;
         end
         default: begin
            pmem_read = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Self-checking bench for cache_mem_arbiter: directed vector
//               table, starvation-guard sequence and randomized traffic
//               checked against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;
   localparam int MAXS   = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_addr;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   cache_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .MAX_D_STREAK(MAXS)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- reference model: who owns pmem, how long I has waited
   int own    = 0;   // 0 none, 1 I-cache, 2 D read, 3 D write-back
   int streak = 0;   // D wins granted while I was asking

   always @(posedge clk) begin
      if (!rst_n) begin
         own    <= 0;
         streak <= 0;
      end else if (own != 0) begin
         if (pmem_resp) own <= 0;
      end else if ((d_read || d_write) && !(i_read && streak >= MAXS)) begin
         own    <= d_write ? 3 : 2;
         streak <= i_read ? ((streak + 1 > MAXS) ? MAXS : streak + 1) : 0;
      end else begin
         own    <= i_read ? 1 : 0;
         streak <= 0;
      end
   end

   always @(negedge clk) begin
      #2;
      if (mon_en) begin
         logic [ADDR_W-1:0] ea;
         logic              eir, edr;
         if (d_read && d_write) begin
            bad++;
            $display("FAIL illegal_stim @%0t: d_read=%0b d_write=%0b", $time, d_read, d_write);
         end
         ea  = (own == 1) ? i_addr : (own >= 2) ? d_addr : '0;
         eir = (own == 1) && pmem_resp;
         edr = (own >= 2) && pmem_resp;
         chk("m_pmem_read",  pmem_read,  (own == 1 || own == 2));
         chk("m_pmem_write", pmem_write, (own == 3));
         chk("m_pmem_addr",  pmem_addr,  ea);
         chk("m_pmem_wdata", pmem_wdata, (own == 3) ? d_wdata : '0);
         chk("m_i_resp",     i_resp,     eir);
         chk("m_d_resp",     d_resp,     edr);
         chk("m_i_rdata",    i_rdata,    eir ? pmem_rdata : '0);
         chk("m_d_rdata",    d_rdata,    edr ? pmem_rdata : '0);
      end
   end

   // ---------------- directed vector table
   typedef struct {
      logic       rst_n, ir, dr, dw, presp;
      logic       e_rd, e_wr, e_ir, e_dr;
      logic [1:0] e_sel;  // 0 none, 1 I addr, 2 D addr
   } vec_t;

   function automatic vec_t v(input logic r, ir, dr, dw, p, erd, ewr, eir, edr,
                              input logic [1:0] sel);
      vec_t x;
      x.rst_n = r; x.ir = ir; x.dr = dr; x.dw = dw; x.presp = p;
      x.e_rd = erd; x.e_wr = ewr; x.e_ir = eir; x.e_dr = edr; x.e_sel = sel;
      return x;
   endfunction

   vec_t vecs[25];

   initial begin
      logic [ADDR_W-1:0] ea;
      string             gq [$];
      string             exp_order [7];
      int                ndone;
      bit                i_prev, d_prev;

      rst_n = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
      i_addr = 32'h0000_0100; d_addr = 32'h8000_0040;
      d_wdata = {16{16'h1234}}; pmem_rdata = {32{8'hA5}};

      //           rst ir dr dw rsp  rd wr ir dr sel
      vecs[0]  = v(0, 1, 0, 1, 0,   0, 0, 0, 0, 0);  // reset held with requests
      vecs[1]  = v(0, 1, 0, 1, 0,   0, 0, 0, 0, 0);
      vecs[2]  = v(1, 1, 0, 1, 0,   0, 0, 0, 0, 0);  // release: arbitrate
      vecs[3]  = v(1, 1, 0, 1, 0,   0, 1, 0, 0, 2);  // D write wins
      vecs[4]  = v(1, 1, 0, 1, 1,   0, 1, 0, 1, 2);
      vecs[5]  = v(1, 1, 0, 0, 0,   0, 0, 0, 0, 0);  // mandatory IDLE
      vecs[6]  = v(1, 1, 0, 0, 0,   1, 0, 0, 0, 1);  // single I read, 3 cycles
      vecs[7]  = v(1, 1, 0, 0, 0,   1, 0, 0, 0, 1);
      vecs[8]  = v(1, 1, 0, 0, 1,   1, 0, 1, 0, 1);
      vecs[9]  = v(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      vecs[10] = v(1, 1, 1, 0, 0,   0, 0, 0, 0, 0);  // collision
      vecs[11] = v(1, 1, 1, 0, 1,   1, 0, 0, 1, 2);  // D first
      vecs[12] = v(1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
      vecs[13] = v(1, 1, 0, 0, 1,   1, 0, 1, 0, 1);  // then I
      vecs[14] = v(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      vecs[15] = v(1, 0, 0, 0, 1,   0, 0, 0, 0, 0);  // stray resp in IDLE
      vecs[16] = v(1, 0, 0, 1, 0,   0, 0, 0, 0, 0);  // write-back
      vecs[17] = v(1, 0, 0, 1, 0,   0, 1, 0, 0, 2);
      vecs[18] = v(1, 0, 0, 0, 1,   0, 1, 0, 1, 2);  // request dropped, still done
      vecs[19] = v(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      vecs[20] = v(1, 1, 0, 0, 0,   0, 0, 0, 0, 0);  // mid-transaction reset
      vecs[21] = v(1, 1, 0, 0, 0,   1, 0, 0, 0, 1);
      vecs[22] = v(0, 1, 0, 0, 0,   1, 0, 0, 0, 1);
      vecs[23] = v(1, 0, 0, 0, 1,   0, 0, 0, 0, 0);  // strobe gone, stray resp ignored
      vecs[24] = v(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);

      @(posedge clk);
      mon_en = 1'b1;

      foreach (vecs[k]) begin
         @(negedge clk);
         rst_n = vecs[k].rst_n; i_read = vecs[k].ir; d_read = vecs[k].dr;
         d_write = vecs[k].dw; pmem_resp = vecs[k].presp;
         #1;
         ea = (vecs[k].e_sel == 2'd1) ? i_addr : (vecs[k].e_sel == 2'd2) ? d_addr : '0;
         chk($sformatf("v%0d_pmem_read", k),  pmem_read,  vecs[k].e_rd);
         chk($sformatf("v%0d_pmem_write", k), pmem_write, vecs[k].e_wr);
         chk($sformatf("v%0d_pmem_addr", k),  pmem_addr,  ea);
         chk($sformatf("v%0d_pmem_wdata", k), pmem_wdata, vecs[k].e_wr ? d_wdata : '0);
         chk($sformatf("v%0d_i_resp", k),     i_resp,     vecs[k].e_ir);
         chk($sformatf("v%0d_d_resp", k),     d_resp,     vecs[k].e_dr);
         chk($sformatf("v%0d_i_rdata", k),    i_rdata,    vecs[k].e_ir ? pmem_rdata : '0);
         chk($sformatf("v%0d_d_rdata", k),    d_rdata,    vecs[k].e_dr ? pmem_rdata : '0);
      end

      // ---------------- starvation guard: I held while D streams 6 reads
      exp_order = '{"D", "D", "D", "D", "I", "D", "D"};
      i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
      i_read = 1'b1; d_read = 1'b1; d_write = 1'b0;
      ndone = 0; i_prev = 1'b0; d_prev = 1'b0;
      for (int c = 0; c < 200 && gq.size() < 7; c++) begin
         @(negedge clk);
         if (i_prev) i_read = 1'b0;
         if (d_prev && ndone == 6) d_read = 1'b0;
         pmem_resp = pmem_read | pmem_write;
         #1;
         i_prev = i_resp;
         d_prev = d_resp;
         if (i_resp) gq.push_back("I");
         if (d_resp) begin gq.push_back("D"); ndone++; end
      end
      total++;
      if (gq.size() != 7) begin
         bad++;
         $display("FAIL starve_count: got %0d grants want 7", gq.size());
      end
      for (int k = 0; k < 7 && k < gq.size(); k++) begin
         total++;
         if (gq[k] != exp_order[k]) begin
            bad++;
            $display("FAIL starve_order[%0d]: got %s want %s", k, gq[k], exp_order[k]);
         end
      end
      @(negedge clk);
      i_read = 1'b0; d_read = 1'b0; pmem_resp = 1'b0;

      // ---------------- randomized traffic against the reference model
      i_prev = 1'b0; d_prev = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 199) != 0);
         if (i_read && i_prev) i_read = 1'b0;
         else if (!i_read && $urandom_range(0, 2) == 0) begin
            i_read = 1'b1;
            i_addr = $urandom & 32'hFFFF_FFE0;
         end
         if ((d_read || d_write) && d_prev) begin
            d_read = 1'b0; d_write = 1'b0;
         end else if (!d_read && !d_write && $urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 1) d_write = 1'b1;
            else d_read = 1'b1;
            d_addr  = $urandom & 32'hFFFF_FFE0;
            d_wdata = {8{$urandom}};
         end
         pmem_resp  = ($urandom_range(0, 2) == 0);
         pmem_rdata = {8{$urandom}};
         #1;
         i_prev = i_resp;
         d_prev = d_resp;
      end

      @(negedge clk);
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
